// File: rtl/dac_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dac_tx_scheduler
// Description : PRT / RF-enable / DAC source sequencer with boundary-shadowed config.
// Revision    : 1.0
// ============================================================================
module dac_tx_scheduler #(
    parameter int CNT_W  = 24,
    parameter int PCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_prt,
    input  logic [CNT_W-1:0]  cfg_guard,
    input  logic [CNT_W-1:0]  cfg_tx_len,
    input  logic              cfg_src,
    output logic              sw_rf,
    output logic [7:0]        dac_mux,
    output logic              wave_start,
    output logic              prt_start,
    output logic              tx_active,
    output logic              busy,
    output logic              cfg_err,
    output logic [PCNT_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GUARD  = 2'd1,
        TX     = 2'd2,
        LISTEN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_PRT_MIN = CNT_W'(2);
    localparam logic [CNT_W:0]   C_ONE_X   = (CNT_W+1)'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_start_state;
    logic [CNT_W-1:0]   r_p;
    logic [CNT_W-1:0]   w_p_nxt;
    logic [CNT_W-1:0]   r_prt_s;
    logic [CNT_W-1:0]   r_guard_s;
    logic [CNT_W-1:0]   r_len_s;
    logic               r_src_s;
    logic               r_cfg_err;
    logic [PCNT_W-1:0]  r_pulse_cnt;

    logic               w_cfg_valid;
    logic               w_load;
    logic [CNT_W:0]     w_p_inc;
    logic               w_last_p;
    logic               w_guard_end;
    logic               w_tx_end;

    // All sums are widened by one bit so large configs cannot wrap.
    assign w_cfg_valid = (cfg_prt >= C_PRT_MIN) && (cfg_tx_len != '0) &&
                         (({1'b0, cfg_guard} + {1'b0, cfg_tx_len}) <= ({1'b0, cfg_prt} - C_ONE_X));

    assign w_p_inc     = {1'b0, r_p} + C_ONE_X;
    assign w_last_p    = (w_p_inc >= {1'b0, r_prt_s});
    assign w_guard_end = (w_p_inc == {1'b0, r_guard_s});
    assign w_tx_end    = (w_p_inc == ({1'b0, r_guard_s} + {1'b0, r_len_s}));

    always_comb begin
        w_start_state = LISTEN;
        if (w_cfg_valid) begin
            w_start_state = (cfg_guard == '0) ? TX : GUARD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_p     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_load      = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
            w_p_nxt     = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_load = enable;
                end
                default: begin
                    if (w_last_p) begin
                        if (enable) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_p_nxt     = '0;
                        end
                    end else begin
                        w_p_nxt = w_p_inc[CNT_W-1:0];
                        if (r_state == GUARD && w_guard_end) begin
                            w_state_nxt = TX;
                        end else if (r_state == TX && w_tx_end) begin
                            w_state_nxt = LISTEN;
                        end
                    end
                end
            endcase
            if (w_load) begin
                w_state_nxt = w_start_state;
                w_p_nxt     = '0;
            end
        end
    end

    // Shadows, sticky error and pulse counter change only at p = 0 entry or pulse end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prt_s     <= '0;
            r_guard_s   <= '0;
            r_len_s     <= '0;
            r_src_s     <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            if (w_load) begin
                r_prt_s   <= cfg_prt;
                r_guard_s <= cfg_guard;
                r_len_s   <= cfg_tx_len;
                r_src_s   <= cfg_src;
                r_cfg_err <= !w_cfg_valid;
            end
            if (w_load && r_state == IDLE) begin
                r_pulse_cnt <= '0;
            end else if (!abort && r_state == TX && w_tx_end) begin
                r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end
        end
    end

    assign sw_rf      = (r_state == TX);
    assign tx_active  = sw_rf;
    assign wave_start = sw_rf && (r_p == r_guard_s);
    assign prt_start  = (r_state != IDLE) && (r_p == '0);
    assign busy       = (r_state != IDLE);
    assign dac_mux    = {7'd0, r_src_s};
    assign cfg_err    = r_cfg_err;
    assign pulse_cnt  = r_pulse_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dac_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_tx_scheduler
// Description : Directed + randomized bench with a period-position reference model.
// Revision    : 1.0
// ============================================================================
module tb_dac_tx_scheduler;

    localparam int CNT_W  = 24;
    localparam int PCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              abort;
    logic [CNT_W-1:0]  cfg_prt;
    logic [CNT_W-1:0]  cfg_guard;
    logic [CNT_W-1:0]  cfg_tx_len;
    logic              cfg_src;
    logic              sw_rf;
    logic [7:0]        dac_mux;
    logic              wave_start;
    logic              prt_start;
    logic              tx_active;
    logic              busy;
    logic              cfg_err;
    logic [PCNT_W-1:0] pulse_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: a running flag plus the position within the period.
    bit     m_run;
    longint m_p, m_prt, m_g, m_len;
    bit     m_src, m_valid, m_err;
    int     m_pc;

    always #5 clk = ~clk;

    dac_tx_scheduler #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .abort      (abort),
        .cfg_prt    (cfg_prt),
        .cfg_guard  (cfg_guard),
        .cfg_tx_len (cfg_tx_len),
        .cfg_src    (cfg_src),
        .sw_rf      (sw_rf),
        .dac_mux    (dac_mux),
        .wave_start (wave_start),
        .prt_start  (prt_start),
        .tx_active  (tx_active),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .pulse_cnt  (pulse_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_start();
        m_prt   = longint'(cfg_prt);
        m_g     = longint'(cfg_guard);
        m_len   = longint'(cfg_tx_len);
        m_src   = cfg_src;
        m_valid = (m_prt >= 2) && (m_len >= 1) && (m_g + m_len <= m_prt - 1);
        m_err   = !m_valid;
        m_p     = 0;
        m_run   = 1'b1;
    endtask

    task automatic m_clock();
        if (!rst_n) begin
            m_run = 0; m_p = 0; m_prt = 0; m_g = 0; m_len = 0;
            m_src = 0; m_valid = 0; m_err = 0; m_pc = 0;
        end else if (abort) begin
            m_run = 0;
            m_p   = 0;
        end else if (!m_run) begin
            if (enable) begin
                m_start();
                m_pc = 0;
            end
        end else begin
            if (m_valid && m_p == m_g + m_len - 1)
                m_pc = (m_pc + 1) % (1 << PCNT_W);
            if (m_p + 1 >= m_prt) begin
                if (enable) m_start();
                else begin
                    m_run = 0;
                    m_p   = 0;
                end
            end else begin
                m_p++;
            end
        end
    endtask

    task automatic check_outputs();
        bit e_rf;
        e_rf = m_run && m_valid && (m_p >= m_g) && (m_p < m_g + m_len);
        check("sw_rf",      32'(sw_rf),      32'(e_rf));
        check("tx_active",  32'(tx_active),  32'(e_rf));
        check("wave_start", 32'(wave_start), 32'(e_rf && m_p == m_g));
        check("prt_start",  32'(prt_start),  32'(m_run && m_p == 0));
        check("busy",       32'(busy),       32'(m_run));
        check("dac_mux",    32'(dac_mux),    32'(m_src));
        check("cfg_err",    32'(cfg_err),    32'(m_err));
        check("pulse_cnt",  32'(pulse_cnt),  32'(m_pc));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m_clock();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic set_cfg(input int prt, input int g, input int len, input bit src);
        cfg_prt    = CNT_W'(prt);
        cfg_guard  = CNT_W'(g);
        cfg_tx_len = CNT_W'(len);
        cfg_src    = src;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; abort = 1'b0;
        set_cfg(20, 3, 5, 1'b0);
        step(3);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Nominal run: one-cycle start latency, three pulses in three periods.
        enable = 1'b1;
        step(1);
        check("start_latency", 32'(prt_start), 32'd1);
        step(59);
        check("three_pulses", 32'(pulse_cnt), 32'd3);

        // Source change mid-period takes effect at the next period start.
        step(6);
        cfg_src = 1'b1;
        step(15);
        check("mux_at_boundary", 32'(dac_mux), 32'd1);

        // Zero guard: RF and period start coincide; then an over-long config.
        set_cfg(20, 0, 19, 1'b1);
        step(20);
        check("g0_sw_rf", 32'(sw_rf), 32'd1);
        check("g0_prt_start", 32'(prt_start), 32'd1);
        step(19);
        check("g0_last_low", 32'(sw_rf), 32'd0);
        set_cfg(20, 1, 19, 1'b1);
        step(1);
        check("bad_cfg_err", 32'(cfg_err), 32'd1);
        step(19);

        // Enable dropped mid-TX: pulse and period complete, then idle.
        set_cfg(20, 3, 5, 1'b0);
        step(1);
        check("err_cleared", 32'(cfg_err), 32'd0);
        step(4);
        enable = 1'b0;
        step(15);
        check("listen_busy", 32'(busy), 32'd1);
        step(1);
        check("idle_after_drop", 32'(busy), 32'd0);
        step(10);

        // Abort mid-pulse, then restart.
        enable = 1'b1;
        step(6);
        abort = 1'b1;
        step(1);
        check("abort_idle", 32'(busy), 32'd0);
        abort = 1'b0;
        step(1);
        check("restart_prt", 32'(prt_start), 32'd1);
        check("restart_cnt", 32'(pulse_cnt), 32'd0);

        // Reset mid-TX overrides enable and abort.
        step(4);
        rst_n = 1'b0; abort = 1'b1;
        step(1);
        check("rst_sw_rf", 32'(sw_rf), 32'd0);
        rst_n = 1'b1; abort = 1'b0;
        step(30);

        // Randomized phase with small configs so boundaries occur often.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 8)
                set_cfg(int'($urandom_range(0, 24)), int'($urandom_range(0, 10)),
                        int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            enable = ($urandom_range(0, 99) < 90);
            abort  = ($urandom_range(0, 99) < 2);
            rst_n  = ($urandom_range(0, 199) != 0);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_tx_scheduler.md
Name: dac_tx_scheduler

Overview:
- Pulse-level sequencer for the radar DAC output path: generates the pulse repetition period (PRT), the RF-enable window (drives the DAC output stage's SW_RF gate) and the DAC source select (waveform I/Q vs DDS).
- Also issues the playback start strobe to the waveform generator.
- Configuration is shadowed and applied only at PRT boundaries, so a TX pulse is never truncated or re-sourced mid-pulse.
- Sits between the radar control registers and the DAC output block.

Parameters:
CNT_W, 24, width of PRT / guard / TX-length counters
PCNT_W, 16, width of the pulse counter

Ports:
clk  in  1  system / DAC clock
rst_n  in  1  synchronous reset, active-low
enable  in  1  run request, level; sampled at PRT boundaries and in IDLE
abort  in  1  immediate stop, pulse or level
cfg_prt  in  CNT_W  PRT length in clk cycles
cfg_guard  in  CNT_W  settle cycles from PRT start to TX start
cfg_tx_len  in  CNT_W  TX window length in cycles
cfg_src  in  1  0 = waveform I/Q, 1 = DDS
sw_rf  out  1  RF enable to the DAC output stage
dac_mux  out  8  source select to the DAC output stage (8'd0 waveform, 8'd1 DDS)
wave_start  out  1  one-cycle strobe on the first TX cycle
prt_start  out  1  one-cycle strobe on cycle 0 of each PRT
tx_active  out  1  equals sw_rf
busy  out  1  state != IDLE
cfg_err  out  1  sticky config error; cleared by reset or by a valid config at a boundary
pulse_cnt  out  PCNT_W  completed TX pulses since leaving IDLE; wraps

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. All outputs 0, dac_mux 8'd0, counters 0. Reset has priority over every other input.
- States: IDLE, GUARD, TX, LISTEN. Period counter p runs 0..prt_s-1 in all non-IDLE states.
- Shadow registers: prt_s, guard_s, len_s, src_s load from cfg_* on the cycle p = 0 is entered. This covers IDLE exit and every wrap.
- Config validity: valid iff prt >= 2, tx_len >= 1, and guard + tx_len <= prt - 1. Evaluate the sum at CNT_W+1 bits so it cannot overflow.
- IDLE -> start: when enable = 1 and abort = 0, the next cycle is p = 0 and prt_start = 1.
  - Config valid: enter GUARD if guard_s > 0, else enter TX directly.
  - Config invalid: set cfg_err, enter LISTEN with sw_rf held 0 for the whole period (a dead period).
- GUARD: sw_rf = 0; dac_mux = src_s from p = 0. Go to TX when p = guard_s - 1.
- TX: sw_rf = 1 for exactly len_s cycles, on p in [guard_s, guard_s + len_s - 1].
  - wave_start = 1 on p = guard_s only.
  - pulse_cnt increments on the last TX cycle.
  - Then go to LISTEN.
- LISTEN: sw_rf = 0. At p = prt_s - 1 the next cycle is the boundary:
  - enable = 1: p = 0, prt_start = 1, reload shadows, re-evaluate config.
  - enable = 0: go to IDLE. Outputs go 0 and dac_mux holds its value.
- enable deasserted during GUARD or TX has no effect until the boundary; the pulse always completes.
- abort = 1 in any state: the next cycle is IDLE, sw_rf = 0, wave_start/prt_start = 0, p = 0.
  - pulse_cnt is retained; it is cleared on the next IDLE exit.
  - abort takes precedence over enable and over the boundary.
- dac_mux changes only at p = 0, never while sw_rf = 1.
- prt_start and sw_rf may coincide only when guard_s = 0.
- Latency: enable rises at cycle n -> prt_start at n+1 -> first sw_rf at n+1+guard.

Test Plan:
- prt = 20, guard = 3, tx_len = 5, src = 0, enable held: prt_start every 20 cycles; sw_rf high for p = 3..7; wave_start at p = 3; dac_mux = 0; pulse_cnt = 1, 2, 3 after successive pulses.
- Same config, cfg_src toggled to 1 at p = 5 of period k: dac_mux stays 0 through period k and becomes 1 at p = 0 of period k+1; sw_rf pulse widths stay 5.
- guard = 0, tx_len = 19, prt = 20: sw_rf and prt_start both high at p = 0; sw_rf low only at p = 19. Then guard = 1, tx_len = 19: cfg_err = 1 and sw_rf is 0 for that whole period.
- enable dropped at p = 4 (mid-TX): pulse completes through p = 7; LISTEN runs to p = 19; IDLE on the next cycle; busy = 0; no further prt_start.
- abort asserted at p = 5: sw_rf = 0 and state IDLE the next cycle. Re-enable: pulse_cnt restarts at 0 and the first prt_start arrives 1 cycle after enable.
- rst_n low for 1 cycle mid-TX: all outputs 0 and cfg_err 0 the next cycle, regardless of enable/abort; operation restarts from IDLE.
